cpu_bus_trace: RTL and testbench

- Passive trace buffer on the 6502C external bus, downstream of top_6502C, in parallel with memory256x256.
- Each cycle_strobe it captures one bus cycle (SYNC, RW, extAB, extDB) into a circular buffer.
- Capture continues through an address-match trigger plus a programmable post-trigger window, then freezes.
- The frozen history is then read out oldest-first over a valid/ready handshake for bench dumps and debug.

---
 rtl/cpu_bus_trace_pkg.sv | 24 ++
 rtl/cpu_bus_trace_ram.sv | 22 ++
 rtl/cpu_bus_trace.sv | 114 +++++++++++
 tb/tb_cpu_bus_trace.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_trace_pkg.sv
// cpu_bus_trace_pkg: trace FSM state encodings and trace entry field layout
package cpu_bus_trace_pkg;
  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_t;
  localparam int ENT_SYNC  = 25;
  localparam int ENT_RW    = 24;
  localparam int ENT_AB_HI = 23;
  localparam int ENT_AB_LO = 8;
  localparam int ENT_DB_HI = 7;
  localparam int ENT_DB_LO = 0;
  function automatic logic [25:0] pack_entry(input logic s, input logic r, input logic [15:0] a, input logic [7:0] d);
    logic [25:0] e;
    e = '0;
    e[ENT_SYNC] = s;
    e[ENT_RW] = r;
    e[ENT_AB_HI:ENT_AB_LO] = a;
    e[ENT_DB_HI:ENT_DB_LO] = d;
    return e;
  endfunction
endpackage

// File: rtl/cpu_bus_trace_ram.sv
// trace_ram: simple dual-port RAM, synchronous write, registered read
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int ENTRY_W = 26
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cpu_bus_trace.sv
// cpu_bus_trace: address-triggered circular capture of 6502 bus cycles with oldest-first readout
module cpu_bus_trace
  import cpu_bus_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int ENTRY_W = 26
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               cycle_strobe,
  input  logic               sync,
  input  logic               rw,
  input  logic [15:0]        ab,
  input  logic [7:0]         db,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [15:0]        trig_addr,
  input  logic [AW-1:0]      post_count,
  output logic [1:0]         state,
  output logic [AW:0]        count,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  trc_state_t st;
  logic [AW-1:0] wr_ptr, rd_ptr, post_cnt, wp_n;
  logic [AW:0] cnt, cnt_n, rd_left;
  logic trig, we, re, xfer, to_done;
  assign state = st;
  assign count = cnt;
  assign trig = (cycle_strobe & sync & (ab == trig_addr)) | force_trig;
  assign we = cycle_strobe & ~arm & (st == TRC_ARMED || st == TRC_POST);
  assign re = ~arm & (st == TRC_DONE) & ~rd_valid & (rd_left != '0);
  assign xfer = rd_valid & rd_ready;
  assign wp_n = wr_ptr + AW'(we);
  assign cnt_n = (cnt == FULL) ? cnt : cnt + (AW+1)'(we);
  // Post-write pointer/count so the trigger/final entry is included in the readout window
  assign to_done = (st == TRC_ARMED && trig && post_count == '0) ||
                   (st == TRC_POST && we && post_cnt == AW'(1));
  trace_ram #(.DEPTH(DEPTH), .AW(AW), .ENTRY_W(ENTRY_W)) u_ram (
    .clock(clock),
    .reset(reset),
    .we(we),
    .waddr(wr_ptr),
    .wdata(ENTRY_W'(pack_entry(sync, rw, ab, db))),
    .re(re),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= TRC_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      rd_left <= '0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else if (arm) begin
      st <= TRC_ARMED;
      wr_ptr <= '0;
      cnt <= '0;
      rd_left <= '0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wp_n;
        cnt <= cnt_n;
      end
      if (to_done) begin
        rd_ptr <= wp_n - cnt_n[AW-1:0];
        rd_left <= cnt_n;
      end
      case (st)
        TRC_ARMED:
          if (trig) begin
            post_cnt <= post_count;
            st <= to_done ? TRC_DONE : TRC_POST;
          end
        TRC_POST:
          if (we) begin
            post_cnt <= post_cnt - AW'(1);
            if (to_done) st <= TRC_DONE;
          end
        TRC_DONE: begin
          if (re) begin
            rd_valid <= 1'b1;
            rd_last <= (rd_left == (AW+1)'(1));
          end
          if (xfer) begin
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            rd_ptr <= rd_ptr + AW'(1);
            rd_left <= rd_left - (AW+1)'(1);
            if (rd_last) begin
              st <= TRC_IDLE;
              cnt <= '0;
            end
          end else if (!rd_valid && rd_left == '0) begin
            st <= TRC_IDLE;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_bus_trace.sv
// tb_cpu_bus_trace: directed vectors and readout sequences for the bus trace buffer
module tb_cpu_bus_trace;
  logic clock = 1'b0, reset = 1'b1, cycle_strobe = 1'b0, sync = 1'b0, rw = 1'b0;
  logic arm = 1'b0, force_trig = 1'b0, rd_ready = 1'b0;
  logic [15:0] ab = '0, trig_addr = '0;
  logic [7:0] db = '0;
  logic [5:0] post_count = '0;
  logic [1:0] state;
  logic [6:0] count;
  logic rd_valid, rd_last;
  logic [25:0] rd_data;
  int vec_n = 0, miss_n = 0;
  logic [25:0] exp_q [$];
  typedef struct {
    logic s; logic r; logic [15:0] a; logic [7:0] d; logic [1:0] st; logic [6:0] cnt;
  } vec_t;
  vec_t tbl [10];

  cpu_bus_trace dut (
    .clock(clock), .reset(reset), .cycle_strobe(cycle_strobe), .sync(sync), .rw(rw),
    .ab(ab), .db(db), .arm(arm), .force_trig(force_trig), .trig_addr(trig_addr),
    .post_count(post_count), .state(state), .count(count), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic strobe(input logic s, input logic r, input logic [15:0] a, input logic [7:0] d);
    cycle_strobe = 1'b1; sync = s; rw = r; ab = a; db = d;
    tick;
    cycle_strobe = 1'b0; sync = 1'b0;
    tick;
  endtask

  task automatic readout(input int n, input bit toggle);
    int idx = 0;
    bit hold = 0;
    logic [25:0] held = '0;
    for (int c = 0; c < 1000 && idx < n; c++) begin
      rd_ready = toggle ? (c % 3 == 0) : 1'b1;
      if (hold) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(held));
      end
      hold = 0;
      if (rd_valid && rd_ready) begin
        chk("rd_data", 32'(rd_data), 32'(exp_q[idx]));
        chk("rd_last", 32'(rd_last), 32'(idx == n - 1));
        idx++;
      end else if (rd_valid) begin
        held = rd_data;
        hold = 1;
      end
      tick;
    end
    rd_ready = 1'b0;
    chk("rd_entries", 32'(idx), 32'(n));
    chk("end_state", 32'(state), 32'd0);
    chk("end_count", 32'(count), 32'd0);
    chk("end_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'h0200, 8'hA2, 2'd1, 7'd1};
    tbl[1] = '{1'b0, 1'b1, 16'h0203, 8'h55, 2'd1, 7'd2};
    tbl[2] = '{1'b0, 1'b0, 16'h01FF, 8'h12, 2'd1, 7'd3};
    tbl[3] = '{1'b1, 1'b1, 16'h0201, 8'hEA, 2'd1, 7'd4};
    tbl[4] = '{1'b1, 1'b1, 16'h0203, 8'hA9, 2'd2, 7'd5};
    tbl[5] = '{1'b0, 1'b1, 16'h0204, 8'h10, 2'd2, 7'd6};
    tbl[6] = '{1'b0, 1'b0, 16'h0300, 8'h33, 2'd2, 7'd7};
    tbl[7] = '{1'b1, 1'b1, 16'h0205, 8'h8D, 2'd3, 7'd8};
    tbl[8] = '{1'b0, 1'b1, 16'h0206, 8'h00, 2'd3, 7'd8};
    tbl[9] = '{1'b1, 1'b1, 16'h0203, 8'hA9, 2'd3, 7'd8};

    tick; tick;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    reset = 1'b0;
    tick;

    // match capture with 3 post-trigger entries
    trig_addr = 16'h0203;
    post_count = 6'd3;
    arm_pulse;
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_count", 32'(count), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      strobe(tbl[i].s, tbl[i].r, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      if (i < 8) exp_q.push_back({tbl[i].s, tbl[i].r, tbl[i].a, tbl[i].d});
    end
    chk("trig_entry", 32'(exp_q[4]), 32'({1'b1, 1'b1, 16'h0203, 8'hA9}));
    readout(8, 1'b0);

    // wrap with 100 strobes, then forced trigger
    arm_pulse;
    for (int k = 1; k <= 100; k++) strobe(1'b0, 1'b1, 16'(16'h1000 + k), 8'(k));
    chk("wrap_state_pre", 32'(state), 32'd1);
    force_trig = 1'b1;
    post_count = 6'd0;
    tick;
    force_trig = 1'b0;
    chk("wrap_state", 32'(state), 32'd3);
    chk("wrap_count", 32'(count), 32'd64);
    exp_q.delete();
    for (int k = 37; k <= 100; k++) exp_q.push_back({1'b0, 1'b1, 16'(16'h1000 + k), 8'(k)});
    readout(64, 1'b0);

    // force trigger with nothing captured
    arm_pulse;
    force_trig = 1'b1;
    tick;
    force_trig = 1'b0;
    chk("empty_state", 32'(state), 32'd3);
    chk("empty_count", 32'(count), 32'd0);
    chk("empty_valid0", 32'(rd_valid), 32'd0);
    tick;
    chk("empty_idle", 32'(state), 32'd0);
    chk("empty_valid1", 32'(rd_valid), 32'd0);
    tick;
    chk("empty_valid2", 32'(rd_valid), 32'd0);

    // arm beats a simultaneous match, then toggled-ready readout
    trig_addr = 16'h0203;
    post_count = 6'd2;
    arm_pulse;
    arm = 1'b1;
    cycle_strobe = 1'b1; sync = 1'b1; rw = 1'b1; ab = 16'h0203; db = 8'h4C;
    tick;
    arm = 1'b0; cycle_strobe = 1'b0; sync = 1'b0;
    tick;
    chk("armwin_state", 32'(state), 32'd1);
    chk("armwin_count", 32'(count), 32'd0);
    exp_q.delete();
    strobe(1'b0, 1'b1, 16'h0400, 8'h11);
    exp_q.push_back({1'b0, 1'b1, 16'h0400, 8'h11});
    strobe(1'b1, 1'b1, 16'h0203, 8'h4C);
    exp_q.push_back({1'b1, 1'b1, 16'h0203, 8'h4C});
    chk("rematch_state", 32'(state), 32'd2);
    strobe(1'b0, 1'b1, 16'h0204, 8'h00);
    exp_q.push_back({1'b0, 1'b1, 16'h0204, 8'h00});
    strobe(1'b0, 1'b0, 16'h0205, 8'h7F);
    exp_q.push_back({1'b0, 1'b0, 16'h0205, 8'h7F});
    chk("rematch_done", 32'(state), 32'd3);
    chk("rematch_count", 32'(count), 32'd4);
    readout(4, 1'b1);

    // reset mid-POST takes effect without waiting for a clock
    post_count = 6'd5;
    arm_pulse;
    strobe(1'b1, 1'b1, 16'h0203, 8'hEA);
    chk("post_state", 32'(state), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rstpost_state", 32'(state), 32'd0);
    chk("rstpost_count", 32'(count), 32'd0);
    chk("rstpost_valid", 32'(rd_valid), 32'd0);
    tick;
    reset = 1'b0;
    tick;

    // reset mid-readout
    arm_pulse;
    strobe(1'b0, 1'b1, 16'h0500, 8'h21);
    force_trig = 1'b1;
    post_count = 6'd0;
    tick;
    force_trig = 1'b0;
    tick;
    chk("rdrst_valid_pre", 32'(rd_valid), 32'd1);
    chk("rdrst_data_pre", 32'(rd_data), 32'({1'b0, 1'b1, 16'h0500, 8'h21}));
    #2 reset = 1'b1;
    #1;
    chk("rdrst_valid", 32'(rd_valid), 32'd0);
    chk("rdrst_data", 32'(rd_data), 32'd0);
    chk("rdrst_last", 32'(rd_last), 32'd0);
    chk("rdrst_state", 32'(state), 32'd0);
    tick;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
